// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encodings,
// default timing parameters, LFSR tap mask and small helpers.
package simon_pkg;

  localparam int N_DEF         = 16;
  localparam int T_ON_DEF      = 4;
  localparam int T_GAP_DEF     = 2;
  localparam int T_TIMEOUT_DEF = 32;

  // Feedback taps for the 8-bit LFSR: bits 7, 5, 4 and 3 are XORed and
  // shifted in at bit 0 while the register shifts left.
  localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_ON    = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ERROR = 3'd5,
    ST_WIN   = 3'd6
  } state_t;

  // Counter width for a count of 'limit' cycles (0..limit-1), never below 1 bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  // Colour code 0..3 to its one-hot LED/button pattern.
  function automatic logic [3:0] colour_onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Player-facing signal bundle of the Simon game controller.
// Handshake: there is no back-pressure. start and btn are single-cycle
// pulses sampled on the rising clk_tick edge (btn only matters in WAIT,
// start only in IDLE/ERROR/WIN); seed is sampled with start in IDLE.
// All outputs are registered and change only on the rising edge (or reset).
interface simon_game_ctrl_if;
  logic       start;
  logic [7:0] seed;
  logic [3:0] btn;
  logic [3:0] led;
  logic       error_led;
  logic       win_led;
  logic [4:0] round;
  logic [2:0] state;
  logic       busy;

  modport master (
    output start, seed, btn,
    input  led, error_led, win_led, round, state, busy
  );

  modport slave (
    input  start, seed, btn,
    output led, error_led, win_led, round, state, busy
  );
endinterface

// File: rtl/simon_lfsr8.sv
// 8-bit left-shifting Fibonacci LFSR used as the colour source.
// A zero seed would lock the register, so it is replaced by 8'h01.
module simon_lfsr8
  import simon_pkg::*;
(
  input  logic       clk_tick,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] q
);

  // Load has priority over advance; otherwise hold.
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      q <= LFSR_RESET;
    end else if (load) begin
      q <= (seed == 8'h00) ? LFSR_RESET : seed;
    end else if (advance) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon memory game controller: generates an N-step colour sequence from an
// LFSR, plays back the first 'round' steps, then checks the player's presses.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int T_ON      = T_ON_DEF,
  parameter int T_GAP     = T_GAP_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic              clk_tick,
  input  logic              reset,
  simon_game_ctrl_if.slave  bus
);

  localparam int RND_W = 5;
  localparam int IDX_W = cnt_w(N);
  localparam int ON_W  = cnt_w(T_ON);
  localparam int GAP_W = cnt_w(T_GAP);
  localparam int TO_W  = cnt_w(T_TIMEOUT);

  localparam logic [RND_W-1:0] ONE_R    = RND_W'(1);
  localparam logic [RND_W-1:0] N_R      = RND_W'(N);
  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(N - 1);
  localparam logic [ON_W-1:0]  ON_ONE   = ON_W'(1);
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(T_ON - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_GAP - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  // An idle cycle that would take the timer to T_TIMEOUT-1 is the fatal one.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(T_TIMEOUT - 2);

  state_t           state_q;
  logic [3:0]       led_q;
  logic             error_q;
  logic             win_q;
  logic             busy_q;
  logic [RND_W-1:0] round_q;
  logic [RND_W-1:0] gen_idx;
  logic [RND_W-1:0] play_idx;
  logic [RND_W-1:0] input_idx;
  logic [ON_W-1:0]  on_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  timer;

  logic [1:0]       seq [N];

  logic [7:0]       lfsr_q;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             lfsr_unused;
  logic [3:0]       btn_exp;
  logic             btn_onehot;

  assign lfsr_load   = (state_q == ST_IDLE) && bus.start;
  assign lfsr_adv    = (state_q == ST_GEN);
  // Only the two low bits pick a colour; the rest is LFSR state.
  assign lfsr_unused = ^lfsr_q[7:2];

  assign btn_exp    = colour_onehot(seq[input_idx[IDX_W-1:0]]);
  assign btn_onehot = (bus.btn != 4'b0000) && ((bus.btn & (bus.btn - 4'd1)) == 4'b0000);

  simon_lfsr8 u_lfsr (
    .clk_tick (clk_tick),
    .reset    (reset),
    .load     (lfsr_load),
    .seed     (bus.seed),
    .advance  (lfsr_adv),
    .q        (lfsr_q)
  );

  // Sequence store: one entry per GEN cycle, contents are don't-care after reset.
  always_ff @(posedge clk_tick) begin
    if (state_q == ST_GEN) begin
      seq[gen_idx[IDX_W-1:0]] <= lfsr_q[1:0];
    end
  end

  // Game FSM with all counters and registered outputs.
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      led_q     <= 4'b0000;
      error_q   <= 1'b0;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      round_q   <= '0;
      gen_idx   <= '0;
      play_idx  <= '0;
      input_idx <= '0;
      on_cnt    <= '0;
      gap_cnt   <= '0;
      timer     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            round_q <= ONE_R;
            gen_idx <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_GEN;
          end
        end

        ST_GEN: begin
          if (gen_idx == LAST_IDX) begin
            // seq[0] was written N-1 cycles ago, so it is safe to show now.
            gen_idx  <= '0;
            play_idx <= '0;
            on_cnt   <= '0;
            led_q    <= colour_onehot(seq[0]);
            state_q  <= ST_ON;
          end else begin
            gen_idx <= gen_idx + ONE_R;
          end
        end

        ST_ON: begin
          if (on_cnt == ON_LAST) begin
            on_cnt   <= '0;
            gap_cnt  <= '0;
            led_q    <= 4'b0000;
            play_idx <= play_idx + ONE_R;
            state_q  <= ST_GAP;
          end else begin
            on_cnt <= on_cnt + ON_ONE;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (play_idx < round_q) begin
              on_cnt  <= '0;
              led_q   <= colour_onehot(seq[play_idx[IDX_W-1:0]]);
              state_q <= ST_ON;
            end else begin
              input_idx <= '0;
              timer     <= '0;
              busy_q    <= 1'b0;
              state_q   <= ST_WAIT;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        ST_WAIT: begin
          if (bus.btn == 4'b0000) begin
            if (timer == TO_LAST) begin
              timer   <= '0;
              error_q <= 1'b1;
              state_q <= ST_ERROR;
            end else begin
              timer <= timer + TO_ONE;
            end
          end else if (btn_onehot && (bus.btn == btn_exp)) begin
            timer <= '0;
            if ((input_idx + ONE_R) == round_q) begin
              input_idx <= '0;
              if (round_q == N_R) begin
                win_q   <= 1'b1;
                led_q   <= 4'b1111;
                state_q <= ST_WIN;
              end else begin
                // Pause one gap before replaying the longer sequence.
                round_q  <= round_q + ONE_R;
                play_idx <= '0;
                gap_cnt  <= '0;
                busy_q   <= 1'b1;
                state_q  <= ST_GAP;
              end
            end else begin
              input_idx <= input_idx + ONE_R;
            end
          end else begin
            timer   <= '0;
            error_q <= 1'b1;
            state_q <= ST_ERROR;
          end
        end

        ST_ERROR, ST_WIN: begin
          // Restart keeps the running LFSR so the next game differs.
          if (bus.start) begin
            error_q <= 1'b0;
            win_q   <= 1'b0;
            led_q   <= 4'b0000;
            round_q <= ONE_R;
            gen_idx <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_GEN;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.led       = led_q;
  assign bus.error_led = error_q;
  assign bus.win_led   = win_q;
  assign bus.round     = round_q;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed testbench for simon_game_ctrl: a default N=16 instance and an
// N=2 instance share the clock; use_n2 routes stimulus and observation.
module tb_simon_game_ctrl;
  import simon_pkg::*;

  localparam int N_BIG   = 16;
  localparam int N_SMALL = 2;
  localparam int TON     = T_ON_DEF;
  localparam int TGAP    = T_GAP_DEF;

  // Clock / reset
  logic clk_tick = 1'b0;
  logic reset;
  always #5 clk_tick = ~clk_tick;

  simon_game_ctrl_if bus16 ();
  simon_game_ctrl_if bus2 ();

  logic       use_n2;
  logic       d_start;
  logic [7:0] d_seed;
  logic [3:0] d_btn;

  assign bus16.start = use_n2 ? 1'b0 : d_start;
  assign bus16.seed  = d_seed;
  assign bus16.btn   = use_n2 ? 4'b0000 : d_btn;
  assign bus2.start  = use_n2 ? d_start : 1'b0;
  assign bus2.seed   = d_seed;
  assign bus2.btn    = use_n2 ? d_btn : 4'b0000;

  logic [3:0] o_led;
  logic       o_err;
  logic       o_win;
  logic [4:0] o_round;
  logic [2:0] o_state;
  logic       o_busy;

  assign o_led   = use_n2 ? bus2.led       : bus16.led;
  assign o_err   = use_n2 ? bus2.error_led : bus16.error_led;
  assign o_win   = use_n2 ? bus2.win_led   : bus16.win_led;
  assign o_round = use_n2 ? bus2.round     : bus16.round;
  assign o_state = use_n2 ? bus2.state     : bus16.state;
  assign o_busy  = use_n2 ? bus2.busy      : bus16.busy;

  simon_game_ctrl dut16 (
    .clk_tick (clk_tick),
    .reset    (reset),
    .bus      (bus16)
  );

  simon_game_ctrl #(.N(N_SMALL)) dut2 (
    .clk_tick (clk_tick),
    .reset    (reset),
    .bus      (bus2)
  );

  // Scoreboard: expected LED pattern per sequence step, plus an LFSR model per instance.
  logic [3:0] exp_q[$];
  logic [7:0] exp_lfsr [2];
  int         cur_n;
  int         total;
  int         bad;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic tick();
    @(posedge clk_tick);
    #1;
  endtask

  // Mirrors one GEN phase: N colours taken from the model LFSR.
  task automatic gen_expected();
    logic [3:0] oh;
    exp_q.delete();
    for (int i = 0; i < cur_n; i++) begin
      oh = 4'b0001 << exp_lfsr[use_n2][1:0];
      exp_q.push_back(oh);
      exp_lfsr[use_n2] = lfsr_step(exp_lfsr[use_n2]);
    end
  endtask

  task automatic load_seed(input logic [7:0] s);
    exp_lfsr[use_n2] = (s == 8'h00) ? 8'h01 : s;
  endtask

  // Steps through a full playback of 'rnd' steps starting with the first LED lit,
  // optionally pulsing btn/start the whole time; ends in WAIT.
  task automatic run_playback(input int rnd, input logic [3:0] noise);
    for (int s = 0; s < rnd; s++) begin
      for (int c = 0; c < TON; c++) begin
        total++; if (o_state !== ST_ON || o_led !== exp_q[s]) begin bad++; $display("FAIL play_on step=%0d cyc=%0d state=%0d led=%b want state=%0d led=%b", s, c, o_state, o_led, ST_ON, exp_q[s]); end
        d_btn = noise; d_start = (noise != 4'b0000); tick();
      end
      for (int g = 0; g < TGAP; g++) begin
        total++; if (o_state !== ST_GAP || o_led !== 4'b0000) begin bad++; $display("FAIL play_gap step=%0d cyc=%0d state=%0d led=%b want state=%0d led=0000", s, g, o_state, o_led, ST_GAP); end
        d_btn = noise; d_start = (noise != 4'b0000); tick();
      end
    end
    d_btn = 4'b0000; d_start = 1'b0;
    total++; if (o_state !== ST_WAIT || o_led !== 4'b0000 || o_busy !== 1'b0) begin bad++; $display("FAIL play_end state=%0d led=%b busy=%b want state=%0d led=0000 busy=0", o_state, o_led, o_busy, ST_WAIT); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      use_n2 = (k == 1);
      #1;
      total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL reset_state dut=%0d got=%0d want=0", k, o_state); end
      total++; if (o_led !== 4'b0000 || o_err !== 1'b0 || o_win !== 1'b0) begin bad++; $display("FAIL reset_leds dut=%0d led=%b err=%b win=%b want all 0", k, o_led, o_err, o_win); end
      total++; if (o_round !== 5'd0 || o_busy !== 1'b0) begin bad++; $display("FAIL reset_round dut=%0d round=%0d busy=%b want 0 0", k, o_round, o_busy); end
    end
    use_n2 = 1'b0;
    reset = 1'b0;
    exp_lfsr[0] = 8'h01;
    exp_lfsr[1] = 8'h01;
    tick();
    total++; if (o_state !== ST_IDLE || o_round !== 5'd0) begin bad++; $display("FAIL idle_hold state=%0d round=%0d want 0 0", o_state, o_round); end
  endtask

  task automatic test_first_playback();
    use_n2 = 1'b0; cur_n = N_BIG;
    d_seed = 8'h01; load_seed(8'h01);
    d_start = 1'b1; tick(); d_start = 1'b0;
    total++; if (o_state !== ST_GEN || o_busy !== 1'b1 || o_round !== 5'd1 || o_led !== 4'b0000) begin bad++; $display("FAIL start_gen state=%0d busy=%b round=%0d led=%b want 1 1 1 0000", o_state, o_busy, o_round, o_led); end
    gen_expected();
    for (int e = 1; e < N_BIG; e++) begin
      if (e == 5) begin d_start = 1'b1; d_btn = 4'b0011; end
      tick();
      d_start = 1'b0; d_btn = 4'b0000;
      total++; if (o_state !== ST_GEN || o_led !== 4'b0000) begin bad++; $display("FAIL gen_hold edge=%0d state=%0d led=%b want %0d 0000", e, o_state, o_led, ST_GEN); end
    end
    tick();
    total++; if (o_state !== ST_ON || o_led !== 4'b0010) begin bad++; $display("FAIL first_led edge=16 state=%0d led=%b want %0d 0010", o_state, o_led, ST_ON); end
    run_playback(1, 4'b0001);
  endtask

  task automatic test_round_advance();
    d_btn = 4'b0010; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_GAP || o_round !== 5'd2 || o_busy !== 1'b1 || o_led !== 4'b0000) begin bad++; $display("FAIL round_adv state=%0d round=%0d busy=%b led=%b want %0d 2 1 0000", o_state, o_round, o_busy, o_led, ST_GAP); end
    tick();
    total++; if (o_state !== ST_GAP) begin bad++; $display("FAIL round_gap state=%0d want %0d", o_state, ST_GAP); end
    tick();
    total++; if (o_state !== ST_ON || o_led !== 4'b0010) begin bad++; $display("FAIL replay_first state=%0d led=%b want %0d 0010", o_state, o_led, ST_ON); end
    run_playback(2, 4'b0000);
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 29; k++) begin
      tick();
      total++; if (o_state !== ST_WAIT) begin bad++; $display("FAIL idle_wait cyc=%0d state=%0d want %0d", k, o_state, ST_WAIT); end
    end
    d_btn = exp_q[0]; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_WAIT || o_err !== 1'b0) begin bad++; $display("FAIL late_press state=%0d err=%b want %0d 0", o_state, o_err, ST_WAIT); end
    for (int k = 1; k <= 30; k++) begin
      tick();
      total++; if (o_state !== ST_WAIT) begin bad++; $display("FAIL idle_wait2 cyc=%0d state=%0d want %0d", k, o_state, ST_WAIT); end
    end
    tick();
    total++; if (o_state !== ST_ERROR || o_err !== 1'b1 || o_led !== 4'b0000 || o_busy !== 1'b0) begin bad++; $display("FAIL timeout state=%0d err=%b led=%b busy=%b want %0d 1 0000 0", o_state, o_err, o_led, o_busy, ST_ERROR); end
  endtask

  task automatic test_mismatch_restart();
    logic [3:0] wrong;
    d_start = 1'b1; tick(); d_start = 1'b0;
    total++; if (o_state !== ST_GEN || o_err !== 1'b0 || o_round !== 5'd1 || o_busy !== 1'b1) begin bad++; $display("FAIL restart state=%0d err=%b round=%0d busy=%b want %0d 0 1 1", o_state, o_err, o_round, o_busy, ST_GEN); end
    gen_expected();
    for (int e = 1; e <= N_BIG; e++) tick();
    total++; if (o_state !== ST_ON || o_led !== exp_q[0]) begin bad++; $display("FAIL restart_led state=%0d led=%b want %0d %b", o_state, o_led, ST_ON, exp_q[0]); end
    run_playback(1, 4'b0000);
    d_start = 1'b1; tick(); d_start = 1'b0;
    total++; if (o_state !== ST_WAIT || o_round !== 5'd1) begin bad++; $display("FAIL start_in_wait state=%0d round=%0d want %0d 1", o_state, o_round, ST_WAIT); end
    wrong = (exp_q[0] == 4'b0001) ? 4'b1000 : 4'b0001;
    d_btn = wrong; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_ERROR || o_err !== 1'b1 || o_led !== 4'b0000) begin bad++; $display("FAIL mismatch state=%0d err=%b led=%b want %0d 1 0000", o_state, o_err, o_led, ST_ERROR); end
  endtask

  task automatic test_multihot();
    d_start = 1'b1; tick(); d_start = 1'b0;
    gen_expected();
    for (int e = 1; e <= N_BIG; e++) tick();
    total++; if (o_state !== ST_ON || o_led !== exp_q[0]) begin bad++; $display("FAIL game3_led state=%0d led=%b want %0d %b", o_state, o_led, ST_ON, exp_q[0]); end
    run_playback(1, 4'b0110);
    d_btn = 4'b0011; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_ERROR || o_err !== 1'b1) begin bad++; $display("FAIL multihot state=%0d err=%b want %0d 1", o_state, o_err, ST_ERROR); end
  endtask

  task automatic test_win();
    use_n2 = 1'b1; cur_n = N_SMALL;
    d_seed = 8'h00; load_seed(8'h00);
    d_start = 1'b1; tick(); d_start = 1'b0;
    gen_expected();
    tick();
    total++; if (o_state !== ST_GEN || o_led !== 4'b0000) begin bad++; $display("FAIL n2_gen state=%0d led=%b want %0d 0000", o_state, o_led, ST_GEN); end
    tick();
    total++; if (o_state !== ST_ON || o_led !== 4'b0010) begin bad++; $display("FAIL n2_first_led state=%0d led=%b want %0d 0010", o_state, o_led, ST_ON); end
    run_playback(1, 4'b0000);
    d_btn = exp_q[0]; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_GAP || o_round !== 5'd2) begin bad++; $display("FAIL n2_round2 state=%0d round=%0d want %0d 2", o_state, o_round, ST_GAP); end
    tick(); tick();
    run_playback(2, 4'b0000);
    d_btn = exp_q[0]; tick();
    total++; if (o_state !== ST_WAIT) begin bad++; $display("FAIL n2_press1 state=%0d want %0d", o_state, ST_WAIT); end
    d_btn = exp_q[1]; tick(); d_btn = 4'b0000;
    total++; if (o_state !== ST_WIN || o_win !== 1'b1 || o_led !== 4'b1111 || o_err !== 1'b0) begin bad++; $display("FAIL win state=%0d win=%b led=%b err=%b want %0d 1 1111 0", o_state, o_win, o_led, o_err, ST_WIN); end
    total++; if (o_round !== 5'd2 || o_busy !== 1'b0) begin bad++; $display("FAIL win_round round=%0d busy=%b want 2 0", o_round, o_busy); end
    tick();
    total++; if (o_state !== ST_WIN || o_led !== 4'b1111) begin bad++; $display("FAIL win_hold state=%0d led=%b want %0d 1111", o_state, o_led, ST_WIN); end
    d_start = 1'b1; tick(); d_start = 1'b0;
    total++; if (o_state !== ST_GEN || o_win !== 1'b0 || o_led !== 4'b0000 || o_round !== 5'd1) begin bad++; $display("FAIL win_restart state=%0d win=%b led=%b round=%0d want %0d 0 0000 1", o_state, o_win, o_led, o_round, ST_GEN); end
    gen_expected();
    tick(); tick();
    total++; if (o_state !== ST_ON || o_led !== exp_q[0]) begin bad++; $display("FAIL n2_game2_led state=%0d led=%b want %0d %b", o_state, o_led, ST_ON, exp_q[0]); end
    tick();
    #1 reset = 1'b1;
    #1;
    total++; if (o_state !== ST_IDLE || o_led !== 4'b0000 || o_round !== 5'd0 || o_busy !== 1'b0 || o_win !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL async_reset state=%0d led=%b round=%0d busy=%b win=%b err=%b want all 0", o_state, o_led, o_round, o_busy, o_win, o_err); end
    tick();
    reset = 1'b0;
    exp_lfsr[0] = 8'h01;
    exp_lfsr[1] = 8'h01;
    tick();
    total++; if (o_state !== ST_IDLE || o_led !== 4'b0000) begin bad++; $display("FAIL post_reset state=%0d led=%b want 0 0000", o_state, o_led); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; use_n2 = 1'b0; cur_n = N_BIG;
    d_start = 1'b0; d_seed = 8'h00; d_btn = 4'b0000;
    exp_lfsr[0] = 8'h01; exp_lfsr[1] = 8'h01;
    #2;
    test_reset();
    test_first_playback();
    test_round_advance();
    test_timeout();
    test_mismatch_restart();
    test_multihot();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter N, default 16: maximum sequence length and the number of rounds needed to win (2..16).
REQ-002 Parameter T_ON, default 4: number of clk_tick cycles each step's LED is lit during playback.
REQ-003 Parameter T_GAP, default 2: number of dark clk_tick cycles after each played step.
REQ-004 Parameter T_TIMEOUT, default 32: number of idle WAIT cycles before a timeout error.
REQ-005 The module SHALL have the following ports:
  clk_tick  in  1  the single clock; all state changes on the rising edge.
  reset  in  1  asynchronous, active-high.
  start  in  1  1-cycle pulse that starts or restarts a game.
  seed  in  8  LFSR seed, sampled on start in IDLE.
  btn  in  4  debounced 1-cycle button pulses; bit i = colour i.
  led  out  4  registered one-hot playback output.
  error_led  out  1  game lost (mismatch or timeout).
  win_led  out  1  all N rounds completed.
  round  out  5  current round, 1..N; 0 in IDLE.
  state  out  3  debug state encoding.
  busy  out  1  high in GEN, ON and GAP.

Function
REQ-010 The states and their encodings SHALL be: IDLE=0, GEN=1, ON=2, GAP=3, WAIT=4, ERROR=5, WIN=6.
REQ-011 In IDLE, start SHALL load the LFSR with seed (8'h00 replaced by 8'h01), set round=1 and go to GEN.
REQ-012 The LFSR SHALL shift left with next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-013 In GEN, each cycle SHALL write seq[gen_idx] = lfsr[1:0] (the value before advancing), then advance the LFSR and gen_idx.
REQ-014 After the write of entry N-1, GEN SHALL go to ON with play_idx=0 and led=onehot(seq[0]) on that same edge.
REQ-015 The first LED SHALL therefore light N edges after the edge that samples start.
REQ-016 ON SHALL hold led for exactly T_ON cycles, then go to GAP with led=0 and play_idx incremented.
REQ-017 GAP SHALL last exactly T_GAP cycles and then exit as follows:
  - play_idx<round: go to ON with the next step.
  - otherwise: go to WAIT with input_idx=0 and the timer cleared.
REQ-018 In WAIT, led SHALL equal 0.
REQ-019 In WAIT, btn=0 SHALL increment the timer; reaching T_TIMEOUT-1 SHALL go to ERROR.
REQ-020 In WAIT, a one-hot btn equal to onehot(seq[input_idx]) SHALL clear the timer and increment input_idx.
REQ-021 In WAIT, a one-hot btn that does not match, or any multi-hot btn, SHALL go to ERROR.
REQ-022 A correct press with input_idx+1==round and round==N SHALL go to WIN.
REQ-023 A correct press with input_idx+1==round and round<N SHALL increment round, set play_idx=0 and go to GAP (inter-round pause before replay).
REQ-024 ERROR SHALL hold error_led=1 and led=0.
REQ-025 WIN SHALL hold win_led=1 and led=4'b1111.
REQ-026 In ERROR and WIN, start SHALL clear both indicator LEDs, set round=1 and go to GEN, keeping the current LFSR state (seed is not reloaded).
REQ-027 start SHALL be ignored in GEN, ON, GAP and WAIT.
REQ-028 btn SHALL be ignored in every state except WAIT.
REQ-029 The ON, GAP and timeout counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.
REQ-030 round SHALL never exceed N.
REQ-031 The sequence storage SHALL be an N x 2-bit register array written only in GEN.

Reset
REQ-040 Reset SHALL asynchronously set:
  - state=IDLE
  - led=0, error_led=0, win_led=0, round=0, busy=0
  - all indices and counters to 0
  - lfsr=8'h01
REQ-041 Reset asserted in any state, including mid-GEN and mid-playback, SHALL abort the game with no residual output, and seq contents SHALL be don't-care.

Structure
REQ-050 Package simon_pkg SHALL hold the state encodings, the default T_ON/T_GAP/T_TIMEOUT/N values and the LFSR tap definition.
REQ-051 Sub-module simon_lfsr8 SHALL be used, with ports clk_tick, reset, load, seed, advance and q.
REQ-052 All FSM, counter and sequence logic SHALL remain in simon_game_ctrl.

Verification
REQ-060 seed=8'h01, start, N=16 -> seq[0..4]=1,2,0,0,1; led=4'b0010 at edge 16, lit 4 cycles, then 2 dark cycles, then WAIT.
REQ-061 Round 1: btn=4'b0010 -> round=2; replay shows 0010 then 0100, then WAIT.
REQ-062 In WAIT round 1: btn=4'b0001 -> ERROR, error_led=1; start -> GEN with error_led=0 and round=1.
REQ-063 In WAIT: no press for 31 cycles -> ERROR on the 31st idle cycle; a press at cycle 30 is accepted.
REQ-064 Multi-hot btn=4'b0011 in WAIT -> ERROR; btn pulses during ON/GAP -> no state change.
REQ-065 N=2: correct presses through round 2 -> WIN, win_led=1, led=1111; reset mid-ON -> all outputs 0 and state=IDLE immediately.
